// File: rtl/multi_clock_divider_if.sv
// Threshold configuration port for multi_clock_divider.
// The master presents cfg_valid/cfg_ch/cfg_threshold and holds them until
// cfg_ready is seen high on a rising clock edge; the divider is the slave.
interface multi_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_threshold;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_threshold,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_threshold,
    output cfg_ready
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider.
// NUM_CH independent 50 % duty divided clocks, period 2*threshold.
// Thresholds are reprogrammed through a valid/ready port: an enabled,
// running channel stages the value in a shadow register that is applied on
// its next wrap (count back at 0, so no runt pulse); a disabled or stopped
// channel takes the value immediately and restarts its count.
// Optional feature macro: CLKDIV_TICK_OUT_EN adds the per-channel tick
// output, a one-cycle registered pulse on every divided-clock edge.
module multi_clock_divider #(
  parameter int NUM_CH            = 4,
  parameter int CNT_W             = 16,
  parameter int DEFAULT_THRESHOLD = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
  multi_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]    dividedClk
`ifdef CLKDIV_TICK_OUT_EN
  ,
  output logic [NUM_CH-1:0]    tick
`endif
);

  localparam logic [CNT_W-1:0] DEF_THR = CNT_W'(DEFAULT_THRESHOLD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Registered per-channel state
  logic [CNT_W-1:0]  cntR    [NUM_CH];
  logic [CNT_W-1:0]  thrR    [NUM_CH];
  logic [CNT_W-1:0]  shadowR [NUM_CH];
  logic [NUM_CH-1:0] pendingR;
  logic [NUM_CH-1:0] divR;

  // Next-state values
  logic [CNT_W-1:0]  cntS    [NUM_CH];
  logic [CNT_W-1:0]  thrS    [NUM_CH];
  logic [CNT_W-1:0]  shadowS [NUM_CH];
  logic [NUM_CH-1:0] pendingS;
  logic [NUM_CH-1:0] divS;

  logic [NUM_CH-1:0] wrapS;
  logic [NUM_CH-1:0] hitS;
  logic              pendSelS;
  logic              xferS;

  // Pending flag of the addressed channel; out-of-range channels read as idle
  always_comb begin
    pendSelS = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        pendSelS = pendingR[i];
      end else begin
        pendSelS = pendSelS;
      end
    end
  end

  assign cfg.cfg_ready = ~pendSelS;
  assign xferS         = cfg.cfg_valid & ~pendSelS;

  // Per-channel wrap detection and write-target decode
  always_comb begin
    wrapS = '0;
    hitS  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable[i] && (thrR[i] != '0) && (cntR[i] == thrR[i] - ONE)) begin
        wrapS[i] = 1'b1;
      end else begin
        wrapS[i] = 1'b0;
      end
      if (xferS && (int'(cfg.cfg_ch) == i)) begin
        hitS[i] = 1'b1;
      end else begin
        hitS[i] = 1'b0;
      end
    end
  end

  // Next-state for count, threshold, shadow, pending and divided clock
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cntS[i]     = cntR[i];
      thrS[i]     = thrR[i];
      shadowS[i]  = shadowR[i];
      pendingS[i] = pendingR[i];
      divS[i]     = divR[i];
      if (thrR[i] == '0) begin
        // stopped channel: parked low, writes land immediately
        cntS[i] = '0;
        divS[i] = 1'b0;
        if (hitS[i]) begin
          thrS[i] = cfg.cfg_threshold;
        end else begin
          thrS[i] = thrR[i];
        end
      end else if (!enable[i]) begin
        // disabled channel: hold count/output, writes restart the count
        if (hitS[i]) begin
          thrS[i] = cfg.cfg_threshold;
          cntS[i] = '0;
        end else begin
          cntS[i] = cntR[i];
        end
      end else begin
        if (wrapS[i]) begin
          cntS[i] = '0;
          divS[i] = ~divR[i];
          if (pendingR[i]) begin
            thrS[i]     = shadowR[i];
            pendingS[i] = 1'b0;
          end else begin
            thrS[i] = thrR[i];
          end
        end else begin
          cntS[i] = cntR[i] + ONE;
        end
        // a write on the wrap edge is staged for the following wrap
        if (hitS[i]) begin
          shadowS[i]  = cfg.cfg_threshold;
          pendingS[i] = 1'b1;
        end else begin
          shadowS[i] = shadowR[i];
        end
      end
    end
  end

  // Channel state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cntR[i]    <= '0;
        thrR[i]    <= DEF_THR;
        shadowR[i] <= '0;
      end
      pendingR <= '0;
      divR     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cntR[i]    <= cntS[i];
        thrR[i]    <= thrS[i];
        shadowR[i] <= shadowS[i];
      end
      pendingR <= pendingS;
      divR     <= divS;
    end
  end

  assign dividedClk = divR;

`ifdef CLKDIV_TICK_OUT_EN
  logic [NUM_CH-1:0] tickR;

  // Tick pulse registered on the same edge that toggles the divided clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tickR <= '0;
    end else begin
      tickR <= wrapS;
    end
  end

  assign tick = tickR;
`endif

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: directed scenarios followed by random
// enables/writes, all checked every cycle against a countdown reference model.
module tb_multi_clock_divider;
  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int DEF = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] dividedClk;
`ifdef CLKDIV_TICK_OUT_EN
  logic [NCH-1:0] tick;
`endif

  always #5 clk = ~clk;

  multi_clock_divider_if #(.NUM_CH(NCH), .CNT_W(CW)) cfgIf ();

  multi_clock_divider #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_THRESHOLD(DEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cfg(cfgIf),
    .dividedClk(dividedClk)
`ifdef CLKDIV_TICK_OUT_EN
    ,
    .tick(tick)
`endif
  );

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model: each channel counts down the enabled cycles left in the
  // current half-period; a staged threshold is held as "next" until used.
  int mLeft [NCH];
  int mThr  [NCH];
  int mNxt  [NCH];
  bit mNxtV [NCH];
  bit mDiv  [NCH];
  bit mTick [NCH];
  bit lastXfer;
  bit wActive;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit expReady();
    int c;
    c = int'(cfgIf.cfg_ch);
    if (c < NCH) return !mNxtV[c];
    return 1'b1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mLeft[i] = DEF; mThr[i] = DEF; mNxt[i] = 0;
      mNxtV[i] = 1'b0; mDiv[i] = 1'b0; mTick[i] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit xfer;
    int c, v;
    xfer = cfgIf.cfg_valid && expReady();
    c    = int'(cfgIf.cfg_ch);
    v    = int'(cfgIf.cfg_threshold);
    for (int i = 0; i < NCH; i++) begin
      mTick[i] = 1'b0;
      if (mThr[i] == 0) begin
        mDiv[i] = 1'b0;
        if (xfer && c == i) begin mThr[i] = v; mLeft[i] = v; end
      end else if (!enable[i]) begin
        if (xfer && c == i) begin mThr[i] = v; mLeft[i] = v; end
      end else begin
        mLeft[i] = mLeft[i] - 1;
        if (mLeft[i] == 0) begin
          mDiv[i]  = !mDiv[i];
          mTick[i] = 1'b1;
          if (mNxtV[i]) begin mThr[i] = mNxt[i]; mNxtV[i] = 1'b0; end
          mLeft[i] = mThr[i];
        end
        if (xfer && c == i) begin mNxt[i] = v; mNxtV[i] = 1'b1; end
      end
    end
    lastXfer = xfer;
  endtask

  task automatic checkOutputs();
    logic [NCH-1:0] expDiv;
    logic [NCH-1:0] expTick;
    for (int i = 0; i < NCH; i++) begin
      expDiv[i]  = mDiv[i];
      expTick[i] = mTick[i];
    end
    checkVal("dividedClk", 32'(dividedClk), 32'(expDiv));
`ifdef CLKDIV_TICK_OUT_EN
    checkVal("tick", 32'(tick), 32'(expTick));
`else
    expTick = '0;
`endif
    checkVal("cfg_ready", 32'(cfgIf.cfg_ready), 32'(expReady()));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) modelEdge();
    else lastXfer = 1'b0;
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic cfgWrite(input int ch, input int val);
    int n;
    cfgIf.cfg_valid     = 1'b1;
    cfgIf.cfg_ch        = 3'(ch);
    cfgIf.cfg_threshold = 8'(val);
    n = 0;
    lastXfer = 1'b0;
    while (!lastXfer && n < 64) begin
      step();
      n++;
    end
    if (!lastXfer) checkVal("cfg_write_timeout", 32'd0, 32'd1);
    cfgIf.cfg_valid = 1'b0;
  endtask

  task automatic waitLeft(input int ch, input int left);
    int n;
    n = 0;
    while (mLeft[ch] != left && n < 64) begin
      step();
      n++;
    end
    if (mLeft[ch] != left) checkVal("wait_count_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int idx;
    reset               = 1'b0;
    enable              = 6'b000001;
    cfgIf.cfg_valid     = 1'b0;
    cfgIf.cfg_ch        = 3'd0;
    cfgIf.cfg_threshold = 8'd0;
    wActive             = 1'b0;
    modelReset();

    // reset state
    repeat (2) @(negedge clk);
    checkVal("reset_div", 32'(dividedClk), 32'd0);
    checkVal("reset_ready", 32'(cfgIf.cfg_ready), 32'd1);
    checkOutputs();
    reset = 1'b1;

    // ch0 at default threshold 3: period 6
    repeat (20) step();

    // ch0 retimed to 5 mid half-period; second write waits for the wrap
    waitLeft(0, 2);
    cfgWrite(0, 5);
    cfgWrite(0, 5);
    repeat (24) step();

    // ch1 disabled: immediate write of 1, then clk/2
    cfgWrite(1, 1);
    enable[1] = 1'b1;
    repeat (10) step();

    // ch2 at 4: freeze for 7 cycles at count 2
    cfgWrite(2, 4);
    enable[2] = 1'b1;
    waitLeft(2, 2);
    enable[2] = 1'b0;
    repeat (7) step();
    enable[2] = 1'b1;
    repeat (12) step();

    // ch3 stopped by threshold 0; out-of-range writes accepted and dropped
    cfgWrite(3, 0);
    enable[3] = 1'b1;
    repeat (6) step();
    cfgWrite(6, 2);
    cfgWrite(7, 1);
    repeat (4) step();

    // asynchronous reset with a staged write on ch0
    cfgWrite(0, 4);
    step();
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkVal("async_reset_div", 32'(dividedClk), 32'd0);
    checkOutputs();
    repeat (2) @(negedge clk);
    checkOutputs();
    reset = 1'b1;
    repeat (20) step();

    // random enables and writes
    enable = NCH'($urandom);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(NCH - 1);
        enable[idx] = ~enable[idx];
      end
      if (!wActive && $urandom_range(3) == 0) begin
        wActive             = 1'b1;
        cfgIf.cfg_valid     = 1'b1;
        cfgIf.cfg_ch        = 3'($urandom_range(7));
        cfgIf.cfg_threshold = 8'($urandom_range(6));
      end
      step();
      if (wActive && lastXfer) begin
        wActive         = 1'b0;
        cfgIf.cfg_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
